mem_tid_alloc: RTL

MEM_TID_ALLOC -- requirements
Module: mem_tid_alloc

---
 rtl/mem_tid_alloc.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_tid_alloc.sv
// ---------------------------------------------------------------------------
// mem_tid_alloc
//
// Transaction-ID allocator for a memory interface. It keeps a pool of
// 2**TidWidth IDs in an allocated bitmap. A request is granted in the same
// cycle, with the lowest free ID. IDs are returned through the free port.
// The number of IDs held at once is capped at MaxOutstanding.
//
// Optional feature (compile-time macro MEM_TID_ALLOC_TIMEOUT_EN):
//   Each ID gets an age counter. When the counter reaches TimeoutCycles-1,
//   a one-cycle timeout pulse is reported for that ID. There is one pulse
//   per allocation. When the macro is undefined, timeout_o and
//   timeout_tid_o are tied to 0.
//
// Ports:
//   clk_i             - clock; all state updates on the rising edge
//   rst_ni            - asynchronous active-low reset
//   flush_i           - releases every ID at the next edge
//   alloc_req_i       - request one ID
//   alloc_gnt_o       - request granted this cycle (combinational)
//   alloc_tid_o       - granted ID (lowest free index)
//   free_valid_i      - return an ID
//   free_tid_i        - ID being returned
//   count_o           - number of IDs currently allocated
//   full_o            - count_o == MaxOutstanding
//   busy_o            - count_o != 0
//   err_double_free_o - one-cycle pulse after freeing an unallocated ID
//   timeout_o         - one-cycle pulse when an ID has aged out
//   timeout_tid_o     - ID reported with timeout_o
// ---------------------------------------------------------------------------
module mem_tid_alloc #(
    parameter int unsigned TidWidth       = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                alloc_req_i,
    output logic                alloc_gnt_o,
    output logic [TidWidth-1:0] alloc_tid_o,
    input  logic                free_valid_i,
    input  logic [TidWidth-1:0] free_tid_i,
    output logic [TidWidth:0]   count_o,
    output logic                full_o,
    output logic                busy_o,
    output logic                err_double_free_o,
    output logic                timeout_o,
    output logic [TidWidth-1:0] timeout_tid_o
);

    localparam int NrIds  = 2 ** TidWidth;
    localparam int CountW = TidWidth + 1;
    localparam logic [CountW-1:0] MaxCount = CountW'(MaxOutstanding);

    logic [NrIds-1:0] allocated;
    logic [NrIds-1:0] allocated_next;
    logic [NrIds-1:0] grant_mask;
    logic [NrIds-1:0] free_mask;
    logic             double_free;

    // Population count of the bitmap. Because the count comes only from
    // registered state, full_o cannot depend on this cycle's request.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < NrIds; i++) begin
            count_o = count_o + CountW'(allocated[i]);
        end
    end

    assign full_o = (count_o == MaxCount);
    assign busy_o = |allocated;

    // Lowest-index free ID. The loop scans from the top, so the last hit
    // wins. When no ID is free the result falls back to 0. The grant is
    // masked by full_o in that case anyway.
    always_comb begin
        alloc_tid_o = '0;
        for (int i = NrIds - 1; i >= 0; i--) begin
            if (!allocated[i]) begin
                alloc_tid_o = TidWidth'(i);
            end
        end
    end

    assign alloc_gnt_o = alloc_req_i & ~full_o & ~flush_i;

    // Next bitmap. The free mask is built against the current bitmap, so
    // an ID released this cycle is not visible to the allocator until the
    // next cycle. A free of an unallocated ID is dropped and flagged. A
    // flush wipes the whole bitmap and suppresses the flag.
    always_comb begin
        grant_mask  = '0;
        free_mask   = '0;
        double_free = 1'b0;
        if (alloc_gnt_o) begin
            grant_mask[alloc_tid_o] = 1'b1;
        end
        if (free_valid_i && !flush_i) begin
            if (allocated[free_tid_i]) begin
                free_mask[free_tid_i] = 1'b1;
            end else begin
                double_free = 1'b1;
            end
        end
        if (flush_i) begin
            allocated_next = '0;
        end else begin
            allocated_next = (allocated | grant_mask) & ~free_mask;
        end
    end

    // Bitmap and double-free flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            allocated         <= '0;
            err_double_free_o <= 1'b0;
        end else begin
            allocated         <= allocated_next;
            err_double_free_o <= double_free;
        end
    end

`ifdef MEM_TID_ALLOC_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

    logic [15:0]         age [NrIds];
    logic [NrIds-1:0]    reported;
    logic [NrIds-1:0]    expired;
    logic                expired_any;
    logic [TidWidth-1:0] expired_tid;

    // An ID is due for reporting when it has aged out and has not been
    // reported yet. It must also survive this edge. An ID that is being
    // freed or flushed right now is dropped silently. Only the lowest due
    // ID is reported in a cycle. The rest stay due and follow in later
    // cycles, in ascending order.
    always_comb begin
        expired = '0;
        for (int i = 0; i < NrIds; i++) begin
            expired[i] = allocated[i] && (age[i] == TimeoutLast) &&
                         !reported[i] && !free_mask[i] && !flush_i;
        end
        expired_any = |expired;
        expired_tid = '0;
        for (int i = NrIds - 1; i >= 0; i--) begin
            if (expired[i]) begin
                expired_tid = TidWidth'(i);
            end
        end
    end

    // Age counters restart on allocation and saturate at the threshold.
    // The reported bits give one pulse per allocation. A reported ID stays
    // allocated until it is freed or flushed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrIds; i++) begin
                age[i] <= '0;
            end
            reported      <= '0;
            timeout_o     <= 1'b0;
            timeout_tid_o <= '0;
        end else begin
            for (int i = 0; i < NrIds; i++) begin
                if (grant_mask[i]) begin
                    age[i]      <= '0;
                    reported[i] <= 1'b0;
                end else if (allocated[i] && (age[i] != TimeoutLast)) begin
                    age[i] <= age[i] + 16'd1;
                end
            end
            if (expired_any) begin
                reported[expired_tid] <= 1'b1;
            end
            timeout_o     <= expired_any;
            timeout_tid_o <= expired_tid;
        end
    end
`else
    assign timeout_o     = 1'b0;
    assign timeout_tid_o = '0;
`endif

endmodule
